ahb5_sram_responder: RTL and testbench
======================================

Name: ahb5_sram_responder

Overview:
- AHB5-Lite subordinate that answers the transfers issued by the team's AHB5 random transaction generators.
- Provides a word-organised SRAM model with byte-lane writes, configurable wait-state insertion (none, fixed, or LFSR-pseudorandom), and a secure/privileged protected region.
- Returns the AHB5 two-cycle ERROR response for illegal accesses.
- Sits on any AHB5 bus in the testbench as the responder end opposite the generators, or beside the xAHB2APB bridge.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 is supported
BASE_ADDR, 32'h2000_0000, first byte address of the memory window
DEPTH, 256, number of 32-bit words; power of two, 4..4096
WAIT_MODE, 0, 0 = zero wait, 1 = FIXED_WAIT per transfer, 2 = pseudorandom 0..MAX_WAIT
FIXED_WAIT, 2, wait cycles in mode 1; 0..15
MAX_WAIT, 3, upper clamp in mode 2; 0..7
LFSR_SEED, 8'hA5, nonzero 8-bit LFSR seed
SECURE_WORDS, 16, words [0, SECURE_WORDS-1] form the protected region; 0 disables protection

Ports:
HCLK  input  1  bus clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  subordinate select
HADDR  input  ADDR_WIDTH  byte address
HTRANS  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
HWRITE  input  1  1 = write
HSIZE  input  3  0 byte, 1 half, 2 word
HPROT  input  4  HPROT[1] = 1 privileged
HNONSEC  input  1  1 = non-secure
HWDATA  input  DATA_WIDTH  write data, valid in data phase
HREADY  input  1  bus-level ready (previous transfer complete)
HREADYOUT  output  1  subordinate ready
HRDATA  output  DATA_WIDTH  read data
HRESP  output  1  0 OKAY, 1 ERROR
err_count  output  16  saturating count of ERROR responses

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous and active-low.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, err_count=0, LFSR=LFSR_SEED. Memory contents are not reset and are retained across reset.
- Transfer acceptance: a transfer is accepted at a rising edge when HSEL & HREADY & HTRANS[1]. The responder latches HADDR, HWRITE, HSIZE, HPROT, HNONSEC into data-phase registers.
- IDLE/BUSY or unselected cycles: no data phase starts; next cycle gives zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Legality check, evaluated on the address phase. The transfer is an error if any of the following holds:
  - address is outside [BASE_ADDR, BASE_ADDR+DEPTH*4-1];
  - HSIZE>2;
  - misaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0);
  - word index < SECURE_WORDS and HNONSEC=1;
  - word index < SECURE_WORDS and HWRITE=1 and HPROT[1]=0.
- FSM states:
  - IDLE: no pending data phase.
  - WAIT: counter>0; HREADYOUT=0, HRESP=0.
  - DATA: final OKAY cycle; HREADYOUT=1.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions on an accepted legal transfer:
  - wait count 0 -> DATA;
  - otherwise -> WAIT with counter=count; decrement each cycle; WAIT -> DATA when the counter reaches 1.
- Transitions on an accepted illegal transfer: -> ERR1 -> ERR2. Wait states are not applied to errors. err_count increments by 1 on entry to ERR1 and saturates at 16'hFFFF.
- Leaving DATA or ERR2: go to the next accepted transfer's state if one is sampled in that cycle (pipelined back-to-back transfers), else IDLE.
- Wait count per mode:
  - mode 0: 0;
  - mode 1: FIXED_WAIT;
  - mode 2: min(LFSR[2:0], MAX_WAIT).
- LFSR: x^8+x^6+x^5+x^4+1 Fibonacci, shifts once per accepted transfer (legal or illegal) in every mode.
- Writes: in the DATA cycle, at the edge ending it, HWDATA lanes selected by latched HSIZE/HADDR[1:0] are written (little-endian). Other lanes are untouched.
- Reads: in the DATA cycle, HRDATA = full word at the latched index (all lanes driven). HRDATA=0 in WAIT, ERR1, ERR2, IDLE and write data phases.
- Read-after-write: a read data phase immediately following a write data phase to the same word returns the newly written data.
- Erroring transfers never modify memory.
- HREADY low from another subordinate: no sampling; state is held.
- In ERR1 the master may drive IDLE; the responder ignores the address phase until HREADYOUT=1.
- Reset asserted mid-transfer: immediate return to reset values. Any write not yet completed is dropped.

Test Plan:
- Mode 0: word write 0xDEADBEEF to BASE+0x40, then read BASE+0x40 back-to-back -> read DATA cycle returns 0xDEADBEEF; HREADYOUT never low.
- Byte writes 0x11 @+0x81, half write 0x2233 @+0x82 over prior word 0 -> read +0x80 returns 0x22331100.
- Mode 1, FIXED_WAIT=2: write then read -> each data phase has exactly 2 cycles HREADYOUT=0 then 1 OKAY cycle; data correct.
- Access BASE+DEPTH*4, word at +0x2, HSIZE=3 -> each produces HRESP=1 with HREADYOUT 0 then 1; memory unchanged; err_count=3.
- SECURE_WORDS=16: HNONSEC=1 read of +0x0 -> ERROR; secure write with HPROT[1]=0 to +0x4 -> ERROR; secure privileged write to +0x4 -> OKAY; readback matches.
- Mode 2, MAX_WAIT=3, seed 8'hA5: 20 random transfers -> per-transfer wait counts match reference LFSR model, all ≤3. Assert HRESETn low during a WAIT state -> HREADYOUT=1, HRESP=0, err_count=0 immediately.

Source files
------------

// File: rtl/ahb5_sram_responder.sv
// AHB5-Lite SRAM responder: word memory with byte-lane writes, selectable wait-state
// insertion and a secure/privileged low region answered with the two-cycle ERROR response.
module ahb5_sram_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 'h2000_0000,
    parameter int                    DEPTH        = 256,
    parameter int                    WAIT_MODE    = 0,
    parameter int                    FIXED_WAIT   = 2,
    parameter int                    MAX_WAIT     = 3,
    parameter logic [7:0]            LFSR_SEED    = 8'hA5,
    parameter int                    SECURE_WORDS = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HNONSEC,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic [15:0]           err_count
);

    localparam int                    IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH * 4);
    localparam logic [IDX_W:0]        SEC_LIMIT = (IDX_W + 1)'(SECURE_WORDS);
    localparam logic [3:0]            FIXED_W   = 4'(FIXED_WAIT);
    localparam logic [3:0]            MAX_W     = 4'(MAX_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state, state_next;
    logic [3:0]              wait_cnt, wait_cnt_next;
    logic [3:0]              wait_sel;
    logic [7:0]              lfsr;
    logic                    lfsr_fb;
    logic                    d_write;
    logic [1:0]              d_size;
    logic [1:0]              d_lane;
    logic [IDX_W-1:0]        d_idx;
    logic [3:0]              byte_en;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        a_idx;
    logic                    in_range;
    logic                    misaligned;
    logic                    in_secure;
    logic                    legal;
    logic                    ready_int;
    logic                    accept;
    logic                    unused_bits;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign unused_bits = ^{HTRANS[0], HPROT[3:2], HPROT[0]};

    // Address-phase decode and legality.
    assign offset     = HADDR - BASE_ADDR;
    assign in_range   = (HADDR >= BASE_ADDR) && (offset < WIN_BYTES);
    assign a_idx      = offset[IDX_W+1:2];
    assign misaligned = ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
    assign in_secure  = {1'b0, a_idx} < SEC_LIMIT;
    assign legal      = in_range && (HSIZE <= 3'd2) && !misaligned &&
                        !(in_secure && (HNONSEC || (HWRITE && !HPROT[1])));

    // WAIT and ERR1 stall the bus, so no address phase can complete there.
    assign ready_int = (state != ST_WAIT) && (state != ST_ERR1);
    assign accept    = HSEL && HREADY && HTRANS[1] && ready_int;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_comb begin
        wait_sel = 4'd0;
        if (WAIT_MODE == 1) begin
            wait_sel = FIXED_W;
        end else if (WAIT_MODE == 2) begin
            wait_sel = ({1'b0, lfsr[2:0]} > MAX_W) ? MAX_W : {1'b0, lfsr[2:0]};
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_DATA;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_next = ST_ERR1;
                    end else if (wait_sel == 4'd0) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = wait_sel;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lfsr      <= LFSR_SEED;
            err_count <= 16'd0;
            d_write   <= 1'b0;
            d_size    <= 2'd0;
            d_lane    <= 2'd0;
            d_idx     <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept) begin
                lfsr    <= {lfsr[6:0], lfsr_fb};
                d_write <= HWRITE;
                d_size  <= HSIZE[1:0];
                d_lane  <= HADDR[1:0];
                d_idx   <= a_idx;
                if (!legal && (err_count != 16'hFFFF)) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

    always_comb begin
        case (d_size)
            2'd0:    byte_en = 4'b0001 << d_lane;
            2'd1:    byte_en = d_lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Memory is deliberately not reset; reset holds state in IDLE so pending writes drop.
    always_ff @(posedge HCLK) begin
        if ((state == ST_DATA) && d_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[d_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HREADYOUT = ready_int;
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign HRDATA    = ((state == ST_DATA) && !d_write) ? mem[d_idx] : '0;

endmodule

// File: tb/tb_ahb5_sram_responder.sv
// Directed bench for ahb5_sram_responder: three instances (zero, fixed and LFSR waits)
// share one AHB bus; a select variable decides which one owns HSEL/HREADY.
module tb_ahb5_sram_responder;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [3:0]  hprot = 4'd0;
    logic        hnonsec = 1'b0;
    logic [31:0] hwdata = '0;
    logic [1:0]  sel = 2'd0;

    logic [2:0]  hsel_dut;
    logic [2:0]  ro;
    logic [2:0]  rs;
    logic [31:0] rd [3];
    logic [15:0] ec [3];
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign hsel_dut = {hsel && (sel == 2'd2), hsel && (sel == 2'd1), hsel && (sel == 2'd0)};

    always_comb begin
        hready = ro[0];
        hresp  = rs[0];
        hrdata = rd[0];
        case (sel)
            2'd1: begin hready = ro[1]; hresp = rs[1]; hrdata = rd[1]; end
            2'd2: begin hready = ro[2]; hresp = rs[2]; hrdata = rd[2]; end
            default: ;
        endcase
    end

    ahb5_sram_responder #(.WAIT_MODE(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_dut[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HPROT(hprot), .HNONSEC(hnonsec), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[0]), .HRDATA(rd[0]), .HRESP(rs[0]), .err_count(ec[0])
    );

    ahb5_sram_responder #(.WAIT_MODE(1), .FIXED_WAIT(2)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_dut[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HPROT(hprot), .HNONSEC(hnonsec), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[1]), .HRDATA(rd[1]), .HRESP(rs[1]), .err_count(ec[1])
    );

    ahb5_sram_responder #(.WAIT_MODE(2), .MAX_WAIT(3), .LFSR_SEED(8'hA5)) u_dut2 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_dut[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HPROT(hprot), .HNONSEC(hnonsec), .HWDATA(hwdata),
        .HREADY(hready), .HREADYOUT(ro[2]), .HRDATA(rd[2]), .HRESP(rs[2]), .err_count(ec[2])
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the bus ready; returns at the negedge of the final data cycle,
    // so a following call overlaps its address phase with that cycle.
    task automatic apply_stimulus(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                                  input logic [3:0] prot, input logic nonsec,
                                  input logic [31:0] wdata, output logic [31:0] rdata,
                                  output logic resp_lo, output logic resp_hi, output int waits);
        haddr   = addr;
        hwrite  = wr;
        hsize   = size;
        hprot   = prot;
        hnonsec = nonsec;
        htrans  = 2'b10;
        hsel    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        htrans  = 2'b00;
        hsel    = 1'b0;
        hwdata  = wdata;
        waits   = 0;
        resp_lo = 1'b0;
        while ((hready !== 1'b1) && (waits < 40)) begin
            resp_lo = hresp;
            waits++;
            @(negedge clk);
        end
        rdata   = hrdata;
        resp_hi = hresp;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rdat;
        logic        rlo;
        logic        rhi;
        int          nw;
        int          exp_wait [20] = '{3, 2, 3, 2, 3, 1, 3, 3, 3, 3,
                                       3, 3, 3, 3, 3, 3, 3, 1, 3, 3};

        repeat (3) @(negedge clk);
        check_output("reset hreadyout", 32'(ro[0]), 32'd1);
        check_output("reset hresp", 32'(rs[0]), 32'd0);
        check_output("reset hrdata", rd[0], 32'd0);
        check_output("reset err_count", 32'(ec[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait write then back-to-back read of the same word.
        sel = 2'd0;
        apply_stimulus(BASE + 32'h40, 1'b1, 3'd2, 4'h3, 1'b0, 32'hDEAD_BEEF, rdat, rlo, rhi, nw);
        check_output("m0 write waits", 32'(nw), 32'd0);
        check_output("m0 write hrdata", rdat, 32'd0);
        check_output("m0 write hresp", 32'(rhi), 32'd0);
        apply_stimulus(BASE + 32'h40, 1'b0, 3'd2, 4'h3, 1'b0, 32'h0, rdat, rlo, rhi, nw);
        check_output("m0 read waits", 32'(nw), 32'd0);
        check_output("m0 read data", rdat, 32'hDEAD_BEEF);

        // Byte and half-word lanes merged into one word.
        apply_stimulus(BASE + 32'h80, 1'b1, 3'd2, 4'h3, 1'b0, 32'h0000_0000, rdat, rlo, rhi, nw);
        apply_stimulus(BASE + 32'h81, 1'b1, 3'd0, 4'h3, 1'b0, 32'h0000_1100, rdat, rlo, rhi, nw);
        apply_stimulus(BASE + 32'h82, 1'b1, 3'd1, 4'h3, 1'b0, 32'h2233_0000, rdat, rlo, rhi, nw);
        apply_stimulus(BASE + 32'h80, 1'b0, 3'd2, 4'h3, 1'b0, 32'h0, rdat, rlo, rhi, nw);
        check_output("lanes read data", rdat, 32'h2233_1100);
        idle_cycle();

        // Illegal accesses: out of range, misaligned word, oversize.
        apply_stimulus(BASE, 1'b1, 3'd2, 4'h2, 1'b0, 32'h5A5A_5A5A, rdat, rlo, rhi, nw);
        check_output("w0 setup hresp", 32'(rhi), 32'd0);
        apply_stimulus(BASE + 32'h400, 1'b1, 3'd2, 4'h2, 1'b0, 32'hFFFF_FFFF, rdat, rlo, rhi, nw);
        check_output("oor err cycles", {29'd0, nw[0], rlo, rhi}, {29'd0, 3'b111});
        apply_stimulus(BASE + 32'h2, 1'b1, 3'd2, 4'h2, 1'b0, 32'hFFFF_FFFF, rdat, rlo, rhi, nw);
        check_output("misalign err cycles", {29'd0, nw[0], rlo, rhi}, {29'd0, 3'b111});
        apply_stimulus(BASE, 1'b1, 3'd3, 4'h2, 1'b0, 32'hFFFF_FFFF, rdat, rlo, rhi, nw);
        check_output("hsize3 err cycles", {29'd0, nw[0], rlo, rhi}, {29'd0, 3'b111});
        check_output("hsize3 waits", 32'(nw), 32'd1);
        apply_stimulus(BASE, 1'b0, 3'd2, 4'h2, 1'b0, 32'h0, rdat, rlo, rhi, nw);
        check_output("w0 unchanged", rdat, 32'h5A5A_5A5A);
        idle_cycle();
        check_output("err_count 3", 32'(ec[0]), 32'd3);

        // Protected region.
        apply_stimulus(BASE, 1'b0, 3'd2, 4'h2, 1'b1, 32'h0, rdat, rlo, rhi, nw);
        check_output("nonsec read err", {30'd0, rlo, rhi}, 32'd3);
        check_output("nonsec read hrdata", rdat, 32'd0);
        apply_stimulus(BASE + 32'h4, 1'b1, 3'd2, 4'h0, 1'b0, 32'h1111_1111, rdat, rlo, rhi, nw);
        check_output("unpriv write err", 32'(rhi), 32'd1);
        apply_stimulus(BASE + 32'h4, 1'b1, 3'd2, 4'h2, 1'b0, 32'h0BAD_F00D, rdat, rlo, rhi, nw);
        check_output("priv write ok", {31'd0, rhi}, 32'd0);
        apply_stimulus(BASE + 32'h4, 1'b0, 3'd2, 4'h2, 1'b0, 32'h0, rdat, rlo, rhi, nw);
        check_output("priv readback", rdat, 32'h0BAD_F00D);
        idle_cycle();
        check_output("err_count 5", 32'(ec[0]), 32'd5);

        // Fixed two wait states.
        sel = 2'd1;
        apply_stimulus(BASE + 32'h200, 1'b1, 3'd2, 4'h2, 1'b0, 32'h1234_5678, rdat, rlo, rhi, nw);
        check_output("m1 write waits", 32'(nw), 32'd2);
        check_output("m1 write hresp", {30'd0, rlo, rhi}, 32'd0);
        apply_stimulus(BASE + 32'h200, 1'b0, 3'd2, 4'h2, 1'b0, 32'h0, rdat, rlo, rhi, nw);
        check_output("m1 read waits", 32'(nw), 32'd2);
        check_output("m1 read data", rdat, 32'h1234_5678);
        idle_cycle();

        // LFSR-driven waits; odd steps read back the word written on the previous step.
        sel = 2'd2;
        for (int i = 0; i < 20; i++) begin
            if ((i % 2) == 0) begin
                apply_stimulus(BASE + 32'h100 + 32'(4 * i), 1'b1, 3'd2, 4'h2, 1'b0,
                               32'hC0DE_0000 | 32'(i), rdat, rlo, rhi, nw);
            end else begin
                apply_stimulus(BASE + 32'h100 + 32'(4 * (i - 1)), 1'b0, 3'd2, 4'h2, 1'b0,
                               32'h0, rdat, rlo, rhi, nw);
                check_output($sformatf("m2 data %0d", i), rdat, 32'hC0DE_0000 | 32'(i - 1));
            end
            check_output($sformatf("m2 waits %0d", i), 32'(nw), 32'(exp_wait[i]));
        end
        idle_cycle();

        // Reset asserted while a write is stalled in WAIT.
        sel     = 2'd1;
        haddr   = BASE + 32'h200;
        hwrite  = 1'b1;
        hsize   = 3'd2;
        hprot   = 4'h2;
        hnonsec = 1'b0;
        htrans  = 2'b10;
        hsel    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        htrans  = 2'b00;
        hsel    = 1'b0;
        hwdata  = 32'hFFFF_FFFF;
        check_output("pre-reset in wait", 32'(hready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_output("async reset hreadyout", 32'(hready), 32'd1);
        check_output("async reset hresp", 32'(hresp), 32'd0);
        check_output("async reset err_count", 32'(ec[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(BASE + 32'h200, 1'b0, 3'd2, 4'h2, 1'b0, 32'h0, rdat, rlo, rhi, nw);
        check_output("dropped write", rdat, 32'h1234_5678);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
